if_id_stage_reg: RTL and testbench

- Consumer end of the fetch interface: IF/ID pipeline register between the fetch stage and decode.
- Captures the fetch stage's PC and instruction each cycle and drives the fetch control inputs back to fetch: freeze, brTaken, brOffset.
- Freezes fetch on load-use stalls from the hazard unit.
- Forwards EX-stage branch redirects to fetch and squashes wrong-path instructions for a parameterised number of fetch cycles.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_stage_reg.sv | 99 +++++++++
 tb/tb_if_id_stage_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: captures fetch PC/instruction, drives freeze and redirect back to fetch, squashes wrong-path slots.
// Latency: fetch -> ID outputs 1 cycle; freeze/brTaken/brOffset/flushIdEx are combinational, same cycle as their causes.
// Backpressure: a load-use stall holds the ID slot and freezes fetch; a taken EX branch overrides the stall.
module if_id_stage_reg #(
    parameter int              IF_LATENCY = 1,
    parameter logic [31:0]     NOP_INSTR  = 32'h0000_0000,
    parameter int              CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PC,
    input  logic [31:0]       instruction,
    input  logic              stallReq,
    input  logic              exBrTaken,
    input  logic              exValid,
    input  logic [31:0]       exBrOffset,
    output logic              freeze,
    output logic              brTaken,
    output logic [31:0]       brOffset,
    output logic              flushIdEx,
    output logic [31:0]       idPC,
    output logic [31:0]       idInstruction,
    output logic              idValid,
    output logic [CNT_W-1:0]  stallCount,
    output logic [CNT_W-1:0]  flushCount
);

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

    // Squash slots still owed after the one loaded on the redirect edge, minus one.
    localparam logic [1:0]       SQ_INIT = (IF_LATENCY > 1) ? 2'(IF_LATENCY - 2) : 2'd0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t     state;
    logic [1:0] sq;
    logic       br;
    logic       run_view;

    assign br        = exBrTaken & exValid;
    // While reset is asserted the control outputs behave as if already in RUN.
    assign run_view  = rst | (state == RUN);
    assign brTaken   = br;
    assign brOffset  = br ? exBrOffset : 32'h0;
    assign flushIdEx = br;
    assign freeze    = stallReq & ~br & run_view;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            sq            <= 2'd0;
            idPC          <= 32'h0;
            idInstruction <= NOP_INSTR;
            idValid       <= 1'b0;
            stallCount    <= '0;
            flushCount    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (br) begin
                        idPC          <= PC;
                        idInstruction <= NOP_INSTR;
                        idValid       <= 1'b0;
                        if (flushCount != CNT_MAX)
                            flushCount <= flushCount + CNT_ONE;
                        if (IF_LATENCY > 1) begin
                            sq    <= SQ_INIT;
                            state <= FLUSH;
                        end
                    end else if (stallReq) begin
                        if (stallCount != CNT_MAX)
                            stallCount <= stallCount + CNT_ONE;
                    end else begin
                        idPC          <= PC;
                        idInstruction <= instruction;
                        idValid       <= 1'b1;
                    end
                end
                FLUSH: begin
                    idPC          <= PC;
                    idInstruction <= NOP_INSTR;
                    idValid       <= 1'b0;
                    if (br) begin
                        // A fresh redirect restarts the squash window.
                        if (flushCount != CNT_MAX)
                            flushCount <= flushCount + CNT_ONE;
                        sq <= SQ_INIT;
                    end else if (sq == 2'd0) begin
                        state <= RUN;
                    end else begin
                        sq <= sq - 2'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Drives three if_id_stage_reg instances (latency 1/16-bit, latency 3/16-bit, latency 3/4-bit counters) with directed then random steps.
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i, ins_i, off_i;
    logic        stall_i, brt_i, bv_i;

    logic        freeze_o [3];
    logic        brt_o    [3];
    logic [31:0] off_o    [3];
    logic        fl_o     [3];
    logic [31:0] idpc_o   [3];
    logic [31:0] idins_o  [3];
    logic        idv_o    [3];
    logic [15:0] sc_o     [3];
    logic [15:0] fc_o     [3];

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: remaining squash slots per instance plus the ID-slot contents.
    int          rem   [3];
    logic [31:0] m_pc  [3];
    logic [31:0] m_ins [3];
    bit          m_val [3];
    bit          m_pck [3];
    int          m_sc  [3];
    int          m_fc  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        localparam int CW  = (g == 2) ? 4 : 16;
        logic [CW-1:0] sc, fc;
        if_id_stage_reg #(.IF_LATENCY(LAT), .NOP_INSTR(NOP), .CNT_W(CW)) u_dut (
            .clk(clk), .rst(rst), .PC(pc_i), .instruction(ins_i),
            .stallReq(stall_i), .exBrTaken(brt_i), .exValid(bv_i), .exBrOffset(off_i),
            .freeze(freeze_o[g]), .brTaken(brt_o[g]), .brOffset(off_o[g]), .flushIdEx(fl_o[g]),
            .idPC(idpc_o[g]), .idInstruction(idins_o[g]), .idValid(idv_o[g]),
            .stallCount(sc), .flushCount(fc)
        );
        assign sc_o[g] = 16'(sc);
        assign fc_o[g] = 16'(fc);
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s[%0d] got %h want %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit br;
        br = brt_i & bv_i;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                rem[k] = 0; m_pc[k] = 0; m_ins[k] = NOP; m_val[k] = 0; m_pck[k] = 1;
                m_sc[k] = 0; m_fc[k] = 0;
            end else if (br) begin
                m_ins[k] = NOP; m_val[k] = 0; m_pck[k] = 0;
                m_fc[k] = (m_fc[k] + 1 > max_of(k)) ? max_of(k) : m_fc[k] + 1;
                rem[k] = lat_of(k) - 1;
            end else if (rem[k] > 0) begin
                m_ins[k] = NOP; m_val[k] = 0; m_pck[k] = 0;
                rem[k] = rem[k] - 1;
            end else if (stall_i) begin
                m_sc[k] = (m_sc[k] + 1 > max_of(k)) ? max_of(k) : m_sc[k] + 1;
            end else begin
                m_pc[k] = pc_i; m_ins[k] = ins_i; m_val[k] = 1; m_pck[k] = 1;
            end
        end
    endtask

    task automatic check_all();
        bit br;
        br = brt_i & bv_i;
        for (int k = 0; k < 3; k++) begin
            chk("brTaken", k, 32'(brt_o[k]), 32'(br));
            chk("brOffset", k, off_o[k], br ? off_i : 32'h0);
            chk("flushIdEx", k, 32'(fl_o[k]), 32'(br));
            chk("freeze", k, 32'(freeze_o[k]), 32'(stall_i & ~br & (rst | (rem[k] == 0))));
            chk("idInstruction", k, idins_o[k], m_ins[k]);
            chk("idValid", k, 32'(idv_o[k]), 32'(m_val[k]));
            if (m_pck[k]) chk("idPC", k, idpc_o[k], m_pc[k]);
            chk("stallCount", k, 32'(sc_o[k]), 32'(m_sc[k]));
            chk("flushCount", k, 32'(fc_o[k]), 32'(m_fc[k]));
        end
    endtask

    task automatic step(bit r, logic [31:0] pc, logic [31:0] ins, bit st, bit bt, bit bv,
                        logic [31:0] off);
        rst = r; pc_i = pc; ins_i = ins; stall_i = st; brt_i = bt; bv_i = bv; off_i = off;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        rst = 1'b1; pc_i = 32'h4; ins_i = 32'h00A0_0093; stall_i = 0; brt_i = 0; bv_i = 0; off_i = 0;
        @(posedge clk);
        model_edge();
        #1;
        // Reset then first capture.
        step(1, 32'h4, 32'h00A0_0093, 0, 0, 0, 0);
        step(0, 32'h4, 32'h00A0_0093, 0, 0, 0, 0);
        step(0, 32'h8, 32'h0010_0113, 0, 0, 0, 0);
        // Three stall cycles while fetch keeps presenting PCs.
        step(0, 32'h8, 32'h0020_0193, 1, 0, 0, 0);
        step(0, 32'hC, 32'h0030_0213, 1, 0, 0, 0);
        step(0, 32'hC, 32'h0030_0213, 1, 0, 0, 0);
        step(0, 32'hC, 32'h0030_0213, 0, 0, 0, 0);
        // Taken branch, then a not-valid EX branch that must be ignored.
        step(0, 32'h10, 32'h1111_1111, 0, 1, 1, 32'h20);
        step(0, 32'h30, 32'h2222_2222, 0, 1, 0, 32'h44);
        step(0, 32'h34, 32'h3333_3333, 0, 0, 0, 0);
        step(0, 32'h38, 32'h4444_4444, 0, 0, 0, 0);
        // Branch coinciding with a stall request, stall held through the flush.
        step(0, 32'h3C, 32'h5555_5555, 1, 1, 1, 32'h100);
        for (int i = 0; i < 4; i++) step(0, 32'h140 + 4 * i, 32'h6000_0000 + i, 1, 0, 0, 0);
        step(0, 32'h150, 32'h7777_7777, 0, 0, 0, 0);
        // Back-to-back redirects: second lands inside the squash window.
        step(0, 32'h154, 32'h8888_8888, 0, 1, 1, 32'h40);
        step(0, 32'h194, 32'h9999_9999, 0, 0, 0, 0);
        step(0, 32'h198, 32'hAAAA_AAAA, 0, 1, 1, 32'h80);
        for (int i = 0; i < 4; i++) step(0, 32'h218 + 4 * i, 32'hB000_0000 + i, 0, 0, 0, 0);
        // Long stall saturates the narrow counter.
        for (int i = 0; i < 20; i++) step(0, 32'h300, 32'hC0DE_0000, 1, 0, 0, 0);
        step(0, 32'h300, 32'hC0DE_0000, 0, 0, 0, 0);
        // Reset in the middle of a flush.
        step(0, 32'h304, 32'hD000_0000, 0, 1, 1, 32'h10);
        step(1, 32'h314, 32'hD000_0001, 1, 0, 0, 0);
        step(0, 32'h318, 32'hD000_0002, 1, 0, 0, 0);
        step(0, 32'h318, 32'hD000_0002, 0, 0, 0, 0);
        step(0, 32'h31C, 32'hD000_0003, 0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99, 0) < 2),
                 $urandom & 32'hFFFF_FFFC, $urandom,
                 ($urandom_range(99, 0) < 35),
                 ($urandom_range(99, 0) < 20),
                 ($urandom_range(99, 0) < 80),
                 $urandom & 32'h0000_0FFC);
        end
        step(0, 32'h0, 32'h0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
